interleave_pingpong_ctrl: RTL and testbench

- Controller/scheduler for a ping-pong block interleaver built from two N-bit banks (N = ROWS*COLS).
- Accepts a serial bit stream from the encoder with a valid/ready handshake and writes each bit row-wise (sequential addresses) into the current write bank.
- Reads each full bank column-wise using the permuted address and sequences bank ownership so that filling and draining overlap.
- Generates all memory controls plus output valid and frame markers. The bit storage sits outside this block.

---
 rtl/interleaver_pkg.sv | 29 ++
 rtl/interleave_bank_fsm.sv | 44 ++++
 rtl/interleave_pingpong_ctrl.sv | 162 ++++++++++++++++
 tb/tb_interleave_pingpong_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interleaver_pkg
// Purpose  : Shared types and helpers for the ping-pong block interleaver
//            controller: bank ownership states, default matrix geometry and
//            the column-wise read permutation.
// Revision : 1.0 - initial release
// ============================================================================
package interleaver_pkg;

    // Ownership lifecycle of one storage bank
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

    localparam int c_def_rows = 4;
    localparam int c_def_cols = 4;

    // Row-wise writes land at idx = r*COLS + c. Reading column-wise means the
    // idx-th read fetches row (idx mod ROWS) of column (idx div ROWS).
    function automatic int perm_addr(input int idx, input int rows, input int cols);
        return (idx % rows) * cols + (idx / rows);
    endfunction

endpackage
`default_nettype wire

// File: rtl/interleave_bank_fsm.sv
`default_nettype none
// ============================================================================
// Module   : interleave_bank_fsm
// Purpose  : Tracks ownership of one interleaver bank. The bank is filled
//            by the writer, handed to the reader once full, and returned to
//            the writer once fully drained.
// Revision : 1.0 - initial release
// ============================================================================
module interleave_bank_fsm
    import interleaver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_start,
    input  logic        wr_last,
    input  logic        rd_start,
    input  logic        rd_last,
    input  logic        flush,
    output bank_state_t state
);

    bank_state_t r_state;

    // Bank lifecycle; flush discards the bank contents regardless of phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (wr_start) r_state <= wr_last ? FULL : FILL;
                FILL:    if (wr_last)  r_state <= FULL;
                FULL:    if (rd_start) r_state <= rd_last ? EMPTY : DRAIN;
                DRAIN:   if (rd_last)  r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/interleave_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interleave_pingpong_ctrl
// Purpose  : Scheduler for a two-bank ping-pong block interleaver. Writes the
//            incoming bit stream row-wise into one bank while the other bank
//            is read column-wise, and generates all bank strobes, addresses
//            and output framing.
// Revision : 1.0 - initial release
// ============================================================================
module interleave_pingpong_ctrl
    import interleaver_pkg::*;
#(
    parameter int ROWS   = c_def_rows,
    parameter int COLS   = c_def_cols,
    parameter int AW     = $clog2(ROWS * COLS),
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          mem_we,
    output logic          mem_wbank,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_re,
    output logic          mem_rbank,
    output logic [AW-1:0] mem_raddr,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eof,
    output logic [15:0]   blk_cnt
);

    localparam int            c_n    = ROWS * COLS;
    localparam logic [AW-1:0] c_last = AW'(c_n - 1);

    logic                     r_wsel;
    logic                     r_rsel;
    logic [AW-1:0]            r_wcnt;
    logic [AW-1:0]            r_rcnt;
    logic [15:0]              r_blk_cnt;
    logic [RD_LAT-1:0][2:0]   r_pipe;

    bank_state_t              w_bank_state [2];
    logic                     w_wr_open;
    logic                     w_rd_avail;
    logic                     w_accept;
    logic                     w_rd;
    logic                     w_wr_first;
    logic                     w_wr_last;
    logic                     w_rd_first;
    logic                     w_rd_last;
    logic [2:0]               w_issue;

    // Writer may use its bank until it is full; reader owns it once full
    assign w_wr_open  = (w_bank_state[r_wsel] == EMPTY) || (w_bank_state[r_wsel] == FILL);
    assign w_rd_avail = (w_bank_state[r_rsel] == FULL)  || (w_bank_state[r_rsel] == DRAIN);

    assign in_ready   = !rst && enable && w_wr_open;
    assign w_accept   = in_valid && in_ready;
    assign w_rd       = enable && out_ready && w_rd_avail;

    assign w_wr_first = (r_wcnt == '0);
    assign w_wr_last  = (r_wcnt == c_last);
    assign w_rd_first = (r_rcnt == '0);
    assign w_rd_last  = (r_rcnt == c_last);

    assign mem_we     = w_accept;
    assign mem_wbank  = r_wsel;
    assign mem_waddr  = r_wcnt;
    assign mem_re     = w_rd;
    assign mem_rbank  = r_rsel;
    assign mem_raddr  = AW'(perm_addr(int'(r_rcnt), ROWS, COLS));
    assign blk_cnt    = r_blk_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic w_wr_hit;
            logic w_rd_hit;

            assign w_wr_hit = w_accept && (r_wsel == 1'(gi));
            assign w_rd_hit = w_rd && (r_rsel == 1'(gi));

            interleave_bank_fsm u_bank_fsm (
                .clk      (clk),
                .rst      (rst),
                .wr_start (w_wr_hit && w_wr_first),
                .wr_last  (w_wr_hit && w_wr_last),
                .rd_start (w_rd_hit && w_rd_first),
                .rd_last  (w_rd_hit && w_rd_last),
                .flush    (flush),
                .state    (w_bank_state[gi])
            );
        end
    endgenerate

    // Write pointer: sequential address in the fill bank, swap bank when full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
            r_wsel <= 1'b0;
        end else if (flush) begin
            r_wcnt <= '0;
            r_wsel <= 1'b0;
        end else if (w_accept) begin
            if (w_wr_last) begin
                r_wcnt <= '0;
                r_wsel <= ~r_wsel;
            end else begin
                r_wcnt <= r_wcnt + AW'(1);
            end
        end
    end

    // Read pointer and completed-block count; the block count survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt    <= '0;
            r_rsel    <= 1'b0;
            r_blk_cnt <= '0;
        end else if (flush) begin
            r_rcnt <= '0;
            r_rsel <= 1'b0;
        end else if (w_rd) begin
            if (w_rd_last) begin
                r_rcnt    <= '0;
                r_rsel    <= ~r_rsel;
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end else begin
                r_rcnt <= r_rcnt + AW'(1);
            end
        end
    end

    // Framing travels with each read so it lines up with the bank data
    assign w_issue = {w_rd, w_rd && w_rd_first, w_rd && w_rd_last};

    generate
        if (RD_LAT == 1) begin : g_lat_one
            // Single-stage delay matching a one-cycle bank read
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_pipe <= '0;
                else     r_pipe <= w_issue;
            end
        end else begin : g_lat_multi
            // Multi-stage delay matching a deeper bank read; reads already
            // issued keep flowing regardless of enable or flush
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_pipe <= '0;
                else     r_pipe <= {r_pipe[RD_LAT-2:0], w_issue};
            end
        end
    endgenerate

    assign {out_valid, out_sof, out_eof} = r_pipe[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_interleave_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interleave_pingpong_ctrl
// Purpose  : Self-checking bench for the ping-pong interleaver controller.
//            Directed table, corner sequences and a randomized run against
//            a count-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interleave_pingpong_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;
    localparam int LAT  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, mem_we, mem_wbank, mem_re, mem_rbank;
    logic [3:0] mem_waddr, mem_raddr;
    logic       out_valid, out_sof, out_eof;
    logic [15:0] blk_cnt;

    logic       in_ready2, mem_we2, mem_wbank2, mem_re2, mem_rbank2;
    logic [3:0] mem_waddr2, mem_raddr2;
    logic       out_valid2, out_sof2, out_eof2;
    logic [15:0] blk_cnt2;

    interleave_pingpong_ctrl #(.ROWS(ROWS), .COLS(COLS), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .mem_we(mem_we), .mem_wbank(mem_wbank), .mem_waddr(mem_waddr),
        .mem_re(mem_re), .mem_rbank(mem_rbank), .mem_raddr(mem_raddr),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .blk_cnt(blk_cnt)
    );

    // Second geometry: 2x8 matrix with a two-cycle bank read
    interleave_pingpong_ctrl #(.ROWS(2), .COLS(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .out_ready(out_ready),
        .mem_we(mem_we2), .mem_wbank(mem_wbank2), .mem_waddr(mem_waddr2),
        .mem_re(mem_re2), .mem_rbank(mem_rbank2), .mem_raddr(mem_raddr2),
        .out_valid(out_valid2), .out_sof(out_sof2), .out_eof(out_eof2),
        .blk_cnt(blk_cnt2)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic iv;
        logic ordy;
        logic rdy;
        logic we;
        logic wbank;
        logic re;
        logic rbank;
        logic ov;
        logic ov2;
        logic sof;
        logic eof;
        int   waddr;
        int   raddr;
        int   raddr2;
        int   blk;
    } vec_t;

    vec_t tbl [34];
    int   perm1 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int   perm2 [16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};

    // Reference model state: bits written / read per bank, bank pointers
    int         m_wr [2];
    int         m_rd [2];
    int         m_wb;
    int         m_rb;
    int         m_blk;
    logic [2:0] hist [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic iv, input logic ordy, input logic fl);
        enable    = en;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Hold reset with all requests active, check outputs, release mid-cycle
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_strobes", 32'({in_ready, mem_we, mem_re, out_valid, out_sof, out_eof, mem_wbank, mem_rbank}), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("rst_addr", 32'({mem_waddr, mem_raddr}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        logic       e, iv, ordy, fl;
        logic       x_rdy, x_acc, x_re;
        int         k;
        logic [2:0] old;

        // Directed table: first two blocks streaming with both handshakes high
        for (int i = 0; i < 34; i++) begin
            tbl[i].iv     = 1'b1;
            tbl[i].ordy   = 1'b1;
            tbl[i].rdy    = 1'b1;
            tbl[i].we     = 1'b1;
            tbl[i].waddr  = i % 16;
            tbl[i].wbank  = ((i / 16) % 2) == 1;
            tbl[i].re     = (i >= 16);
            tbl[i].raddr  = (i >= 16) ? perm1[(i - 16) % 16] : 0;
            tbl[i].raddr2 = (i >= 16) ? perm2[(i - 16) % 16] : 0;
            tbl[i].rbank  = (i >= 32);
            tbl[i].ov     = (i >= 17);
            tbl[i].ov2    = (i >= 18);
            tbl[i].sof    = (i == 17) || (i == 33);
            tbl[i].eof    = (i == 32);
            tbl[i].blk    = (i >= 32) ? 1 : 0;
        end

        do_reset();
        for (int i = 0; i < 34; i++) begin
            drive(1'b1, tbl[i].iv, tbl[i].ordy, 1'b0);
            #3;
            chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].rdy));
            chk("tbl_mem_we", 32'(mem_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk("tbl_waddr", 32'(mem_waddr), tbl[i].waddr);
                chk("tbl_wbank", 32'(mem_wbank), 32'(tbl[i].wbank));
            end
            chk("tbl_mem_re", 32'(mem_re), 32'(tbl[i].re));
            chk("tbl_mem_re2", 32'(mem_re2), 32'(tbl[i].re));
            if (tbl[i].re) begin
                chk("tbl_raddr", 32'(mem_raddr), tbl[i].raddr);
                chk("tbl_rbank", 32'(mem_rbank), 32'(tbl[i].rbank));
                chk("tbl_raddr_2x8", 32'(mem_raddr2), tbl[i].raddr2);
            end
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ov));
            chk("tbl_out_valid_lat2", 32'(out_valid2), 32'(tbl[i].ov2));
            chk("tbl_out_sof", 32'(out_sof), 32'(tbl[i].sof));
            chk("tbl_out_eof", 32'(out_eof), 32'(tbl[i].eof));
            chk("tbl_blk_cnt", 32'(blk_cnt), tbl[i].blk);
            tick();
        end

        // Flush with one block in flight on each side
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        #3;
        chk("flush_inflight_valid", 32'(out_valid), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            #3;
            chk("flush_no_read", 32'(mem_re), 32'd0);
            chk("flush_in_ready", 32'(in_ready), 32'd1);
            chk("flush_blk_kept", 32'(blk_cnt), 32'd1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #3;
        chk("flush_first_we", 32'(mem_we), 32'd1);
        chk("flush_first_wbank", 32'(mem_wbank), 32'd0);
        chk("flush_first_waddr", 32'(mem_waddr), 32'd0);
        tick();

        // Backpressure: both banks fill, then one drain re-opens the writer
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        acc = 0;
        for (int j = 0; j < 100; j++) begin
            #3;
            if (!in_ready) break;
            acc++;
            tick();
        end
        chk("bp_accepts", acc, 32);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 16; j++) begin
            #3;
            chk("bp_ready_held_low", 32'(in_ready), 32'd0);
            chk("bp_drain_re", 32'(mem_re), 32'd1);
            tick();
        end
        #3;
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_wbank", 32'(mem_wbank), 32'd0);
        tick();

        // Asynchronous reset in the middle of a drain
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (16) tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (9) tick();
        #3;
        chk("mid_drain_re", 32'(mem_re), 32'd1);
        chk("mid_drain_raddr", 32'(mem_raddr), 32'd6);
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        chk("async_rst_strobes", 32'({in_ready, mem_we, mem_re, out_valid, out_sof, out_eof}), 32'd0);
        chk("async_rst_addr", 32'({mem_raddr, mem_waddr}), 32'd0);
        chk("async_rst_blk", 32'(blk_cnt), 32'd0);
        tick();
        rst = 1'b0;
        #3;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_we", 32'(mem_we), 32'd1);
        chk("post_rst_wbank", 32'(mem_wbank), 32'd0);
        chk("post_rst_waddr", 32'(mem_waddr), 32'd0);
        tick();

        // Randomized run against the reference model
        do_reset();
        m_wr  = '{0, 0};
        m_rd  = '{0, 0};
        m_wb  = 0;
        m_rb  = 0;
        m_blk = 0;
        hist.delete();
        for (int j = 0; j < LAT; j++) hist.push_back(3'b000);
        for (int c = 0; c < 3000; c++) begin
            e    = ($urandom_range(0, 7) != 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 99) == 0);
            drive(e, iv, ordy, fl);
            #3;
            x_rdy = e && (m_wr[m_wb] < N);
            x_acc = iv && x_rdy;
            x_re  = e && ordy && (m_wr[m_rb] == N);
            k     = m_rd[m_rb];
            old   = hist.pop_front();
            chk("rnd_in_ready", 32'(in_ready), 32'(x_rdy));
            chk("rnd_mem_we", 32'(mem_we), 32'(x_acc));
            if (x_acc) begin
                chk("rnd_waddr", 32'(mem_waddr), m_wr[m_wb]);
                chk("rnd_wbank", 32'(mem_wbank), m_wb);
            end
            chk("rnd_mem_re", 32'(mem_re), 32'(x_re));
            if (x_re) begin
                chk("rnd_raddr", 32'(mem_raddr), (k % ROWS) * COLS + k / ROWS);
                chk("rnd_rbank", 32'(mem_rbank), m_rb);
            end
            chk("rnd_out_frame", 32'({out_valid, out_sof, out_eof}), 32'(old));
            chk("rnd_blk_cnt", 32'(blk_cnt), m_blk % 65536);
            hist.push_back({x_re, x_re && (k == 0), x_re && (k == N - 1)});
            if (fl) begin
                m_wr = '{0, 0};
                m_rd = '{0, 0};
                m_wb = 0;
                m_rb = 0;
            end else begin
                if (x_acc) begin
                    m_wr[m_wb]++;
                    if (m_wr[m_wb] == N) m_wb ^= 1;
                end
                if (x_re) begin
                    m_rd[m_rb]++;
                    if (m_rd[m_rb] == N) begin
                        m_wr[m_rb] = 0;
                        m_rd[m_rb] = 0;
                        m_rb ^= 1;
                        m_blk++;
                    end
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
